// File: rtl/muldiv_pkg.sv
// Shared types and operand-signedness helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  // MUL is sign-agnostic in its low word, so it runs on raw unsigned operands.
  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div_op(muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One iteration of the datapath: radix-2 shift-add multiply or restoring shift-subtract divide.
module muldiv_core_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           no_borrow;

  // Multiply keeps the product in {hi, lo}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    sum       = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    shifted   = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff      = shifted - {1'b0, operand};
    no_borrow = (shifted >= {1'b0, operand});
    if (is_div) begin
      acc_out = {(no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_in[WIDTH-2:0], no_borrow};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake and abort-on-flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [RWIDTH-1:0] rd_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [RWIDTH-1:0] rd_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e      state, next_state;
  muldiv_op_e         op_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_q, b_q, operand;
  logic               sign_a, sign_b, neg_res, neg_rem;
  logic [2*WIDTH-1:0] acc, step_acc, prod;
  logic [WIDTH-1:0]   mag_a, mag_b, fix_result;
  logic               div_by_zero, div_ovf, special;

  muldiv_core_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_op(op_q)),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (step_acc)
  );

  always_comb begin
    mag_a       = sign_a ? -a_q : a_q;
    mag_b       = sign_b ? -b_q : b_q;
    div_by_zero = (b_q == '0);
    div_ovf     = is_signed_b(op_q) && (a_q == MOST_NEG) && (b_q == '1);
    special     = is_div_op(op_q) && (div_by_zero || div_ovf);
  end

  always_comb begin
    prod       = neg_res ? -acc : acc;
    fix_result = '0;
    case (op_q)
      OP_MUL:                       fix_result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_result = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      default:                      fix_result = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Flush wins over everything, but only while enabled.
  always_comb begin
    next_state = state;
    if (en) begin
      if (flush_i) begin
        next_state = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (start_i) next_state = ST_PREP;
          ST_PREP: next_state = special ? ST_FIX : ST_CALC;
          ST_CALC: if (count == LAST_COUNT) next_state = ST_FIX;
          ST_FIX:  next_state = ST_DONE;
          default: next_state = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy_o = (state == ST_PREP) || (state == ST_CALC) || (state == ST_FIX);
    done_o = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      operand  <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      count    <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else if (en && !flush_i) begin
      case (state)
        ST_IDLE: if (start_i) begin
          op_q   <= muldiv_op_e'(op_i);
          rd_o   <= rd_i;
          a_q    <= a_i;
          b_q    <= b_i;
          sign_a <= is_signed_a(muldiv_op_e'(op_i)) & a_i[WIDTH-1];
          sign_b <= is_signed_b(muldiv_op_e'(op_i)) & b_i[WIDTH-1];
        end
        ST_PREP: begin
          count <= '0;
          // Special divides preload the final quotient/remainder so FIX passes them through.
          if (is_div_op(op_q)) begin
            operand <= mag_b;
            if (div_by_zero) begin
              acc     <= {a_q, {WIDTH{1'b1}}};
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
            end else if (div_ovf) begin
              acc     <= {{WIDTH{1'b0}}, a_q};
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
            end else begin
              acc     <= {{WIDTH{1'b0}}, mag_a};
              neg_res <= sign_a ^ sign_b;
              neg_rem <= sign_a;
            end
          end else begin
            operand <= mag_a;
            acc     <= {{WIDTH{1'b0}}, mag_b};
            neg_res <= sign_a ^ sign_b;
            neg_rem <= 1'b0;
          end
        end
        ST_CALC: begin
          acc   <= step_acc;
          count <= count + CW'(1);
        end
        ST_FIX:  result_o <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed RV32M results and latencies.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32), .RWIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush_i  (flush_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_i     (rd_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive a start so that the next rising edge (edge 0) samples it.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    rd_i    = rd;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic waitDone(output int edges, output int gaps);
    edges = 0;
    gaps  = 0;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (done_o) break;
      if (!busy_o) gaps++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                       input int exp_lat);
    int edges, gaps;
    applyStimulus(op, a, b, rd);
    checkOutput({tag, "_busy0"}, 32'(busy_o), 32'd1);
    waitDone(edges, gaps);
    checkOutput({tag, "_lat"}, 32'(edges), 32'(exp_lat));
    checkOutput({tag, "_res"}, result_o, exp_res);
    checkOutput({tag, "_rd"}, 32'(rd_o), 32'(rd));
    checkOutput({tag, "_busygap"}, 32'(gaps), 32'd0);
    checkOutput({tag, "_donebusy"}, 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_idle"}, 32'({done_o, busy_o}), 32'd0);
  endtask

  initial begin
    int edges, gaps;
    rst     = 1'b0;
    en      = 1'b1;
    flush_i = 1'b0;
    start_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    rd_i    = '0;
    #1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_rd", 32'(rd_o), 32'd0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    runOp("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 34);
    runOp("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 34);
    runOp("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 34);
    runOp("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
    runOp("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34);
    runOp("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34);
    runOp("divu", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 34);
    runOp("remu", OP_REMU, 32'd100, 32'd7, 5'd10, 32'd2, 34);
    runOp("div_by0", OP_DIV, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 2);
    runOp("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd12, 32'd5, 2);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 2);
    runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 2);

    // A second start while CALC is running must not disturb the operation.
    applyStimulus(OP_REMU, 32'd100, 32'd7, 5'd15);
    repeat (5) begin @(posedge clk); #1; end
    op_i = OP_MUL; a_i = 32'd3; b_i = 32'd3; rd_i = 5'd16; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    waitDone(edges, gaps);
    checkOutput("ign_lat", 32'(edges + 6), 32'd34);
    checkOutput("ign_res", result_o, 32'd2);
    checkOutput("ign_rd", 32'(rd_o), 32'd15);
    @(posedge clk);
    #1;

    // Flush while count is 10: back to IDLE, no done, result untouched.
    applyStimulus(OP_MUL, 32'd3, 32'd3, 5'd17);
    repeat (11) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checkOutput("flush_busy", 32'(busy_o), 32'd0);
    checkOutput("flush_done", 32'(done_o), 32'd0);
    checkOutput("flush_res", result_o, 32'd2);
    runOp("after_flush", OP_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, 34);

    // Stall for three cycles mid-CALC; done moves out by exactly three edges.
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd19);
    repeat (10) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    en = 1'b1;
    waitDone(edges, gaps);
    checkOutput("stall_lat", 32'(edges + 13), 32'd37);
    checkOutput("stall_res", result_o, 32'hFFFF_FFFD);
    en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stall_done_hold", 32'(done_o), 32'd1);
    en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall_done_drop", 32'(done_o), 32'd0);

    // Asynchronous reset while count is 5.
    applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20);
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy_o), 32'd0);
    checkOutput("arst_done", 32'(done_o), 32'd0);
    checkOutput("arst_res", result_o, 32'd0);
    checkOutput("arst_rd", 32'(rd_o), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("arst_idle", 32'({done_o, busy_o}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit with a parametrised WIDTH. It handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the ALU in the execute stage. The hazard unit holds the pipeline while busy_o is high, and the result enters the M stage on done_o.
- Adds multi-cycle execution, which the single-cycle pipeline lacks, using a start/busy/done handshake with abort-on-flush.

Parameters:
- WIDTH, 32, operand and result width (≥4, even).
- RWIDTH, 5, destination register index width.

Ports:
- clk  in  1  CPU clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- en  in  1  global enable; when 0, all state holds.
- flush_i  in  1  FlushE from hazard unit; aborts the current operation.
- start_i  in  1  request; accepted only in IDLE with en=1.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  WIDTH  rs1 operand (forwarded).
- b_i  in  WIDTH  rs2 operand (forwarded).
- rd_i  in  RWIDTH  destination register.
- busy_o  out  1  high in PREP, CALC and FIX.
- done_o  out  1  one-cycle pulse; result_o and rd_o are valid.
- result_o  out  WIDTH  result; held until the next accepted start.
- rd_o  out  RWIDTH  latched rd_i.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy_o=0, done_o=0, result_o=0, rd_o=0.
  - Counter and datapath registers = 0.
- FSM states: IDLE → PREP → CALC → FIX → DONE → IDLE.
- IDLE:
  - start_i=1, en=1 and flush_i=0: latch op, rd, the operands and the operand signs; go to PREP.
  - start_i while not IDLE is ignored.
- PREP (1 cycle):
  - Form unsigned magnitudes. Operands are signed for MULH, DIV and REM; a only for MULHSU; neither for MULHU, DIVU and REMU. MUL uses unsigned magnitudes (the low word is sign-agnostic).
  - Divide special cases skip CALC and go straight to FIX:
    - b=0: quotient = all ones, remainder = a.
    - Signed a = most-negative and b = −1: quotient = a, remainder = 0.
  - Otherwise go to CALC with count=0.
- CALC (exactly WIDTH cycles, count 0..WIDTH−1):
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Leave for FIX when count=WIDTH−1.
- FIX (1 cycle):
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - The remainder takes the sign of the dividend.
  - Select: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register the selection into result_o; go to DONE.
- DONE (1 cycle): done_o=1; next state IDLE.
- Latency, with edge 0 = the edge that samples start:
  - Normal operation: done_o is high in the cycle after edge WIDTH+2 (edge 34 for WIDTH=32).
  - Special divide cases: done_o is high after edge 2.
  - Back-to-back: the next start is accepted at the earliest in IDLE, one cycle after DONE.
- flush_i=1 in any state: next state IDLE, no done_o, result_o unchanged. flush_i has priority over start_i and over the DONE→IDLE transition.
- en=0: state, counter, datapath and outputs all hold. done_o stays asserted if it was set, so the pulse lengthens; consumers qualify with en. flush_i is ignored while en=0.
- Reset mid-operation: immediate return to the reset values; no done_o.
- All arithmetic is modulo 2^WIDTH, with no exceptions raised, per the RISC-V spec.

Decomposition:
- muldiv_pkg:
  - muldiv_op_e enum (the 8 funct3 codes).
  - muldiv_state_e enum (IDLE, PREP, CALC, FIX, DONE).
  - is_signed_a and is_signed_b functions of op.
- One natural sub-module, muldiv_core_step: the combinational single iteration (add-shift or subtract-shift), selected by an is_div input. It keeps the FSM file focused on control.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3) → after edge 34, done_o=1, result_o=0xFFFFFFEB; busy_o high for edges 1..33.
- MULH a=b=0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5%0 → 5, with done_o after edge 2; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, also after edge 2.
- flush_i at CALC count 10 → IDLE next cycle, no done_o, result_o keeps its old value; a new start is accepted on the following cycle. start_i asserted during CALC is ignored.
- rst=0 at CALC count 5 → outputs zero immediately; en=0 for 3 cycles mid-CALC → done_o is delayed by exactly 3 cycles with a correct result.
